// File: rtl/serial_word_rx_if.sv
// Receiver-side signal bundle for the serial word link: the line in, the received word and status out.
// Defining SERIAL_RX_PARITY_EN adds the parityErr status line.
interface serial_word_rx_if #(
  parameter int WORD_W = 32
);
  logic              RxD;
  logic [WORD_W-1:0] dataIn;
  logic              dataValid;
  logic              frameErr;
  logic              busy;
`ifdef SERIAL_RX_PARITY_EN
  logic              parityErr;

  modport master (output RxD, input dataIn, input dataValid, input frameErr, input busy,
                  input parityErr);
  modport slave  (input RxD, output dataIn, output dataValid, output frameErr, output busy,
                  output parityErr);
`else
  modport master (output RxD, input dataIn, input dataValid, input frameErr, input busy);
  modport slave  (input RxD, output dataIn, output dataValid, output frameErr, output busy);
`endif
endinterface

// File: rtl/serial_word_rx.sv
// Deserializes an idle-high, start/stop framed, LSB-first line into WORD_W-bit words.
// Defining SERIAL_RX_PARITY_EN adds an even-parity bit between the last data bit and the stop bit.
module serial_word_rx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int WORD_W       = 32
) (
  input logic             clk,
  input logic             rst_n,
  serial_word_rx_if.slave rx
);
  localparam int DIV_W = $clog2(CLKS_PER_BIT);
  localparam int IDX_W = $clog2(WORD_W);
  localparam logic [DIV_W-1:0] HALF_TC  = DIV_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [DIV_W-1:0] FULL_TC  = DIV_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef SERIAL_RX_PARITY_EN
    S_PARITY,
`endif
    S_STOP,
    S_BREAK
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        sync_q, sync_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              ferr_q, ferr_d;
  logic              rx_s;
  logic              div_tc;
`ifdef SERIAL_RX_PARITY_EN
  logic              par_q, par_d;
  logic              perr_q, perr_d;
`endif

  assign rx_s = sync_q[1];

  always_comb begin
    sync_d  = {sync_q[0], rx.RxD};
    state_d = state_q;
    div_d   = div_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    par_d   = par_q;
    perr_d  = 1'b0;
`endif
    // The half-bit terminal count in START shifts every later sample to mid-bit.
    div_tc  = (state_q == S_START) ? (div_q == HALF_TC) : (div_q == FULL_TC);

    unique case (state_q)
      S_IDLE: begin
        div_d = '0;
        if (!rx_s) state_d = S_START;
      end
      S_START: begin
        if (div_tc) begin
          div_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? S_IDLE : S_DATA;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_DATA: begin
        if (div_tc) begin
          div_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == LAST_IDX) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`ifdef SERIAL_RX_PARITY_EN
      S_PARITY: begin
        if (div_tc) begin
          div_d   = '0;
          par_d   = rx_s;
          state_d = S_STOP;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif
      S_STOP: begin
        if (div_tc) begin
          div_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
`ifdef SERIAL_RX_PARITY_EN
            if ((^shift_q) ^ par_q) begin
              perr_d = 1'b1;
            end else begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end
`else
            data_d  = shift_q;
            valid_d = 1'b1;
`endif
          end else begin
            ferr_d  = 1'b1;
            state_d = S_BREAK;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      S_BREAK: begin
        div_d = '0;
        if (rx_s) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= 2'b11;
      state_q <= S_IDLE;
      div_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      perr_q  <= 1'b0;
`endif
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
`ifdef SERIAL_RX_PARITY_EN
      perr_q  <= perr_d;
`endif
    end
  end

  // Assembly registers are only meaningful once committed, so they carry no reset.
  always_ff @(posedge clk) begin
    shift_q <= shift_d;
`ifdef SERIAL_RX_PARITY_EN
    par_q   <= par_d;
`endif
  end

  assign rx.dataIn    = data_q;
  assign rx.dataValid = valid_q;
  assign rx.frameErr  = ferr_q;
  assign rx.busy      = (state_q != S_IDLE);
`ifdef SERIAL_RX_PARITY_EN
  assign rx.parityErr = perr_q;
`endif
endmodule

// File: doc/serial_word_rx.md
Name: serial_word_rx

Overview:
- Receive side of the team's 32-bit serial word link: deserializes one line into 32-bit words and flags each completed word.
- Frame on the line:
  - idle-high line;
  - 1 start bit (0);
  - 32 data bits, LSB first;
  - 1 stop bit (1).
- Sits at the far end of the serial word transmitter and feeds received words to the pipeline processor's input stage.
- Bit timing comes from a fixed clock-divider parameter. There is no oversampling beyond mid-bit sampling.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per serial bit; minimum 4; even values only.
- WORD_W, 32, data bits per frame; legal range 8..32.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- RxD  input  1  serial line, asynchronous to clk; idles high.
- dataIn  output  WORD_W  last correctly received word.
- dataValid  output  1  one-cycle pulse when dataIn updates.
- frameErr  output  1  one-cycle pulse on bad stop bit.
- busy  output  1  high while a frame is in progress (any state other than IDLE).

Behaviour:
- Reset (async, rst_n=0):
  - dataIn=0, dataValid=0, frameErr=0, busy=0.
  - State=IDLE; bit counter and divider counter cleared.
  - Synchronizer flops set to 1.
- Input synchronization: RxD passes through a 2-flop synchronizer (rx_s). All decisions use rx_s, so line-to-decision latency is 2 cycles.
- State IDLE:
  - Divider held at 0.
  - On rx_s==0, go to START.
- State START:
  - Divider counts to CLKS_PER_BIT/2-1.
  - At terminal count: if rx_s==0, clear the divider, set bit index=0, go to DATA.
  - Otherwise treat it as a glitch and return to IDLE with no pulse.
- State DATA:
  - Divider counts 0..CLKS_PER_BIT-1; at terminal count, sample rx_s into shift register bit [index].
  - Samples land mid-bit because the count is offset by the half-bit in START.
  - After bit WORD_W-1 is sampled, go to STOP.
- State STOP:
  - At terminal count, sample rx_s.
  - If 1: dataIn <= shift register; dataValid=1 for exactly the next cycle; go to IDLE.
  - If 0: frameErr=1 for exactly the next cycle; dataIn unchanged; go to BREAK.
- State BREAK: wait until rx_s==1, then go to IDLE. A held-low line never produces repeated errors.
- Latency:
  - dataValid rises 1 cycle after the mid-stop-bit sample.
  - That is approx. (WORD_W+1.5)*CLKS_PER_BIT+3 cycles after the start-bit falling edge on RxD.
- Back-to-back frames:
  - A new start bit arriving immediately after the stop bit's midpoint is accepted.
  - IDLE is re-entered before the next falling edge.
- dataValid and frameErr are never both high. Neither is high while rst_n=0.
- Reset mid-frame: the frame is discarded with no pulse. The next frame is received normally once rst_n=1 and the line has returned high.
- dataIn holds its value between frames. Shift register contents are not visible until commit.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- When defined:
  - An even-parity bit follows the last data bit; a PARITY state samples it one CLKS_PER_BIT after the last data bit.
  - New output port parityErr (1 bit, reset 0).
  - On a valid stop bit with wrong parity: parityErr pulses 1 cycle, dataValid is not asserted, and dataIn is unchanged.
  - On a good frame, behaviour matches the baseline.
- When undefined: no PARITY state, no parityErr port, frame exactly as above.

Test Plan:
- Reset, then frame 0xAA0FCC55 with CLKS_PER_BIT=16 -> one dataValid pulse; dataIn=0xAA0FCC55; frameErr=0; busy low afterwards.
- Two back-to-back frames, 0xFF00FF00 then 0x00000001, with no idle gap -> two dataValid pulses; dataIn=0xFF00FF00, then 0x00000001.
- RxD low pulse of 3 cycles while IDLE -> no pulses; busy returns to 0 within CLKS_PER_BIT/2+3 cycles; dataIn unchanged.
- Frame 0x12345678 with stop bit forced 0, line held low 100 cycles -> exactly one frameErr pulse; dataIn keeps its previous value; the next good frame, 0xDEADBEEF, is received.
- rst_n asserted low mid-way through data bit 10 of a frame -> all outputs 0 immediately; the following frame 0x0000FFFF is received correctly.
- With SERIAL_RX_PARITY_EN: frame 0x00000007 with parity bit 0 -> parityErr pulse, no dataValid. The same frame with parity bit 1 -> dataValid, dataIn=0x00000007.
